// File: rtl/ahb_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_sram_slave                                                  |
// | Purpose  : AHB-Lite responder backed by a word-organised internal SRAM.    |
// |            Pipelined address/data phases, byte-lane writes by HSIZE,       |
// |            two-cycle ERROR responses, optional wait states.                |
// | Macro    : AHB_SRAM_WAIT_EN - when defined, each OKAY data phase inserts   |
// |            WAIT_CYCLES stall cycles; when undefined every OKAY transfer    |
// |            is zero-wait and the wait counter is not built.                 |
// | Ports    : HCLK, HRESET (sync, active-high)                                |
// |            HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY  in  |
// |            HRDATA, HREADYOUT, HRESP                                   out  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ahb_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h2000_0000,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                  c_idx_w     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] c_win_bytes = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
`ifdef AHB_SRAM_WAIT_EN
  localparam int                  c_wait      = WAIT_CYCLES;
`else
  // Wait states are disabled in this build; WAIT_CYCLES has no effect.
  localparam int                  c_wait      = WAIT_CYCLES * 0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [c_idx_w-1:0]      r_idx;
  logic [1:0]              r_lane;
  logic [1:0]              r_size;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_err;
  logic                    w_take;
  logic                    w_we;
  logic [3:0]              w_be;
  logic                    w_unused;

  // Address decode for the transfer currently in its address phase.
  assign w_offset = HADDR - BASE_ADDR;
  assign w_err    = (HADDR < BASE_ADDR)
                  | ({1'b0, w_offset} >= c_win_bytes)
                  | (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  // A new transfer is taken only in a state that completes its own phase,
  // so a stalled address phase held by the master is never re-sampled.
  assign w_take   = HSEL & HTRANS[1] & HREADY & HREADYOUT;

  // Only transfer-type bit 1 and the low offset bits matter; bursts are
  // decoded beat by beat.
  assign w_unused = ^{HTRANS[0], HBURST};

  // State-driven response outputs.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      S_WAIT:  HREADYOUT = 1'b0;
      S_ERR1:  begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      S_ERR2:  HRESP     = 1'b1;
      default: ;
    endcase
  end

`ifdef AHB_SRAM_WAIT_EN
  logic [3:0] r_wait_cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wait_cnt <= 4'd0;
    end else if ((w_next == S_WAIT) && (r_state != S_WAIT)) begin
      r_wait_cnt <= 4'(WAIT_CYCLES - 1);
    end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (w_take) begin
          if (w_err)            w_next = S_ERR1;
          else if (c_wait == 0) w_next = S_DATA;
          else                  w_next = S_WAIT;
        end else begin
          w_next = S_IDLE;
        end
      end
`ifdef AHB_SRAM_WAIT_EN
      S_WAIT: if (r_wait_cnt == 4'd0) w_next = S_DATA;
`endif
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_size  <= 2'b00;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_idx   <= w_offset[c_idx_w+1:2];
        r_lane  <= HADDR[1:0];
        r_size  <= HSIZE[1:0];
        r_write <= HWRITE;
      end
    end
  end

  // Byte-lane enables; errored transfers never reach DATA, so size 3 is moot.
  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // A reset landing on the commit edge drops the pending write.
  assign w_we = (r_state == S_DATA) & r_write & ~HRESET;

  // Memory contents survive reset.
  always_ff @(posedge HCLK) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  // Combinational read: a read accepted on a write's commit edge sees the
  // freshly written word.
  assign HRDATA = ((r_state == S_DATA) && !r_write) ? r_mem[r_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ahb_sram_slave                                               |
// | Purpose  : Self-checking bench for ahb_sram_slave with a word-array        |
// |            reference model and randomized traffic.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ahb_sram_slave;

  localparam int          AW    = 32;
  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 1024;
  localparam int          WCYC  = 2;
`ifdef AHB_SRAM_WAIT_EN
  localparam int          C_WAIT = WCYC;
`else
  localparam int          C_WAIT = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [0:DEPTH-1];

  ahb_sram_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(BASE),
    .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WCYC)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  // Single-slave bus: the bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  function automatic bit is_err(logic [31:0] a, logic [2:0] s);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= longint'(DEPTH * 4)) return 1'b1;
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && (a % 2) != 0) return 1'b1;
    if (s == 3'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_write(logic [31:0] a, logic [2:0] s, logic [31:0] d);
    int idx, first, cnt;
    idx   = int'((a - BASE) >> 2);
    first = int'(a % 4);
    cnt   = 1 << s;
    for (int b = first; b < first + cnt; b++) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HADDR = 32'h0; HWDATA = 32'h0;
  endtask

  // One isolated transfer: address phase, then data phase checked against the model.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, input string tag);
    bit e; int n; int idx; logic [31:0] exp;
    e = is_err(a, s);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = s;
    HBURST = 3'($urandom_range(0, 7));
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    if (e) begin
      @(negedge HCLK);
      checks++;
      if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
        errors++;
        $display("FAIL %s err1: ready=%b resp=%b rdata=%h, want ready=0 resp=1 rdata=0",
                 tag, HREADYOUT, HRESP, HRDATA);
      end
      @(negedge HCLK);
      checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
        errors++;
        $display("FAIL %s err2: ready=%b resp=%b rdata=%h, want ready=1 resp=1 rdata=0",
                 tag, HREADYOUT, HRESP, HRDATA);
      end
    end else begin
      n = 0;
      @(negedge HCLK);
      while (HREADYOUT !== 1'b1 && n < 20) begin
        checks++;
        if (HRESP !== 1'b0 || HRDATA !== 32'h0) begin
          errors++;
          $display("FAIL %s wait: resp=%b rdata=%h, want resp=0 rdata=0", tag, HRESP, HRDATA);
        end
        n++;
        @(negedge HCLK);
      end
      checks++;
      if (n != C_WAIT) begin
        errors++;
        $display("FAIL %s waits: got %0d, want %0d", tag, n, C_WAIT);
      end
      idx = int'((a - BASE) >> 2);
      if (wr) begin
        model_write(a, s, wd);
        exp = 32'h0;
      end else begin
        exp = ref_mem[idx];
      end
      checks++;
      if (HRESP !== 1'b0 || HRDATA !== exp) begin
        errors++;
        $display("FAIL %s data: resp=%b rdata=%h, want resp=0 rdata=%h", tag, HRESP, HRDATA, exp);
      end
    end
  endtask

  task automatic test_reset();
    bus_idle();
    HRESET = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
        errors++;
        $display("FAIL reset: ready=%b resp=%b rdata=%h, want 1 0 0", HREADYOUT, HRESP, HRDATA);
      end
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    // Selected IDLE and BUSY transfers give zero-wait OKAY with no data phase.
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = BASE; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HTRANS = 2'b01;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL idle_busy: ready=%b resp=%b rdata=%h, want 1 0 0", HREADYOUT, HRESP, HRDATA);
    end
    @(posedge HCLK); #1;
    bus_idle();
  endtask

  task automatic test_word();
    xfer(1'b1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, "word_wr");
    xfer(1'b0, BASE + 32'h10, 3'd2, 32'h0, "word_rd");
    xfer(1'b1, BASE + DEPTH*4 - 4, 3'd2, 32'hA5A5_0F0F, "last_wr");
    xfer(1'b0, BASE + DEPTH*4 - 4, 3'd2, 32'h0, "last_rd");
  endtask

  task automatic test_byte_half();
    xfer(1'b1, BASE + 32'h20, 3'd2, 32'h0000_0000, "bh_clear");
    xfer(1'b1, BASE + 32'h21, 3'd0, 32'h0000_AA00, "bh_byte");
    xfer(1'b1, BASE + 32'h22, 3'd1, 32'h1234_0000, "bh_half");
    xfer(1'b0, BASE + 32'h20, 3'd2, 32'h0, "bh_read");
    checks++;
    if (ref_mem[8] !== 32'h1234_AA00) begin
      errors++;
      $display("FAIL bh_model: got %h, want 1234aa00", ref_mem[8]);
    end
  endtask

  task automatic test_errors();
    xfer(1'b1, BASE, 3'd2, 32'h1111_2222, "err_init");
    xfer(1'b0, BASE + 32'h2, 3'd2, 32'h0, "err_misalign_rd");
    xfer(1'b1, BASE + 32'h2, 3'd2, 32'hFFFF_FFFF, "err_misalign_wr");
    xfer(1'b1, BASE + DEPTH*4, 3'd2, 32'hFFFF_FFFF, "err_above");
    xfer(1'b1, BASE - 4, 3'd2, 32'hFFFF_FFFF, "err_below");
    xfer(1'b1, BASE + 32'h1, 3'd1, 32'hFFFF_FFFF, "err_half_odd");
    xfer(1'b1, BASE, 3'd3, 32'hFFFF_FFFF, "err_size3");
    xfer(1'b0, BASE, 3'd2, 32'h0, "err_unchanged");
  endtask

  // Write followed immediately by a read of the same word; the read address
  // phase is held across any write wait states.
  task automatic test_back_to_back();
    logic [31:0] a, v, exp;
    int n;
    for (int k = 0; k < 4; k++) begin
      a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
      v = $urandom;
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = a;
      @(posedge HCLK); #1;
      HTRANS = 2'b11; HWRITE = 1'b0; HWDATA = v;
      n = 0;
      @(negedge HCLK);
      while (HREADYOUT !== 1'b1 && n < 20) begin n++; @(negedge HCLK); end
      checks++;
      if (n != C_WAIT || HRESP !== 1'b0) begin
        errors++;
        $display("FAIL b2b_wr: waits=%0d resp=%b, want waits=%0d resp=0", n, HRESP, C_WAIT);
      end
      model_write(a, 3'd2, v);
      exp = ref_mem[int'((a - BASE) >> 2)];
      @(posedge HCLK); #1;
      bus_idle();
      n = 0;
      @(negedge HCLK);
      while (HREADYOUT !== 1'b1 && n < 20) begin n++; @(negedge HCLK); end
      checks++;
      if (n != C_WAIT || HRESP !== 1'b0 || HRDATA !== exp) begin
        errors++;
        $display("FAIL b2b_rd: waits=%0d resp=%b rdata=%h, want waits=%0d resp=0 rdata=%h",
                 n, HRESP, HRDATA, C_WAIT, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [2:0]  s;
    int          idx;
    for (int i = 0; i < 9; i++) begin
      idx = (i == 8) ? DEPTH - 1 : 16 + i;
      xfer(1'b1, BASE + 32'(idx) * 4, 3'd2, $urandom, "rnd_fill");
    end
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 8);
      idx = (idx == 8) ? DEPTH - 1 : 16 + idx;
      s   = 3'($urandom_range(0, 2));
      case (s)
        3'd0:    a = BASE + 32'(idx) * 4 + 32'($urandom_range(0, 3));
        3'd1:    a = BASE + 32'(idx) * 4 + 32'($urandom_range(0, 1)) * 2;
        default: a = BASE + 32'(idx) * 4;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       begin a = BASE - 4; s = 3'd2; end
          1:       a = BASE + DEPTH*4 + 32'($urandom_range(0, 3) & 2);
          2:       begin a = BASE + 32'(idx) * 4 + 1; s = 3'd2; end
          default: begin a = BASE + 32'(idx) * 4; s = 3'd3; end
        endcase
      end
      d = $urandom;
      xfer(1'($urandom_range(0, 1)), a, s, d, "rnd");
    end
    for (int i = 0; i < 9; i++) begin
      idx = (i == 8) ? DEPTH - 1 : 16 + i;
      xfer(1'b0, BASE + 32'(idx) * 4, 3'd2, 32'h0, "rnd_final");
    end
  endtask

  task automatic test_reset_mid_write();
    xfer(1'b1, BASE + 32'h80, 3'd2, 32'hCAFE_0001, "rst_init_a");
    xfer(1'b1, BASE + 32'h84, 3'd2, 32'hCAFE_0002, "rst_init_b");
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = BASE + 32'h80;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BAD_0BAD; HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: ready=%b resp=%b rdata=%h, want 1 0 0", HREADYOUT, HRESP, HRDATA);
    end
    xfer(1'b0, BASE + 32'h80, 3'd2, 32'h0, "rst_keep_a");
    xfer(1'b0, BASE + 32'h84, 3'd2, 32'h0, "rst_keep_b");
    xfer(1'b0, BASE + 32'h10, 3'd2, 32'h0, "rst_keep_c");
  endtask

  initial begin
    HRESET = 1'b1;
    bus_idle();
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    repeat (2) @(posedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite responder with an internal word-organised SRAM. It is the target end of the bus that the DMA master and the CPU drive. The block decodes address and data phases with full pipelining and writes byte lanes according to HSIZE. It returns OKAY, wait-state or two-cycle ERROR responses through HREADYOUT/HRESP.

Parameters:
ADDR_WIDTH, 32, HADDR width.
DATA_WIDTH, 32, bus and memory word width; only 32 is supported.
BASE_ADDR, 32'h2000_0000, first byte address of the SRAM window.
DEPTH_WORDS, 1024, number of memory words; window size is DEPTH_WORDS*4 bytes.
WAIT_CYCLES, 2, wait states inserted per OKAY data phase; used only when AHB_SRAM_WAIT_EN is defined; range 0-15.

Ports:
HCLK  in  1  bus clock; all logic on its rising edge.
HRESET  in  1  reset; synchronous, active-high.
HSEL  in  1  slave select from the decoder.
HADDR  in  ADDR_WIDTH  byte address (address phase).
HTRANS  in  2  transfer type: IDLE, BUSY, NONSEQ or SEQ.
HWRITE  in  1  1 = write, 0 = read.
HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
HBURST  in  3  burst type; accepted and ignored, since each beat is decoded independently.
HWDATA  in  DATA_WIDTH  write data (data phase).
HREADY  in  1  bus-level ready (muxed HREADYOUT of the active slave).
HRDATA  out  DATA_WIDTH  read data (data phase).
HREADYOUT  out  1  1 = this slave's data phase completes this cycle.
HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Accept: a transfer is accepted on an edge where HSEL & HTRANS[1] & HREADY are all high. On accept, register the address, HWRITE, HSIZE and the error decision into data-phase registers.
- IDLE/BUSY: transfers of these types, and unselected cycles, get a zero-wait OKAY and create no data phase.
- Error decision, evaluated at accept time. Any one of these makes the transfer an error:
  - HADDR < BASE_ADDR, or HADDR - BASE_ADDR >= DEPTH_WORDS*4;
  - HSIZE > 2;
  - HSIZE = 1 with HADDR[0] = 1;
  - HSIZE = 2 with HADDR[1:0] != 0.
- FSM states and their outputs:
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0.
  - DATA: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions out of IDLE, DATA or ERR2 (each of these completes a phase):
  - accept with error -> ERR1;
  - accept OK with effective wait count 0 -> DATA;
  - accept OK with wait count > 0 -> WAIT, loading the wait counter with WAIT_CYCLES-1;
  - no accept -> IDLE.
- WAIT: decrement the counter each cycle; at 0 go to DATA. ERR1 always goes to ERR2.
- Effective wait count is 0 when AHB_SRAM_WAIT_EN is undefined.
- Write commit: in DATA with HREADYOUT=1, write HWDATA into mem[word index] at the clock edge.
  - Byte lanes are selected by size and address: byte -> lane addr[1:0]; halfword -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes.
  - Unselected lanes are unchanged.
- Read data: in the DATA state of a read, HRDATA = mem[registered word index] read combinationally, so latency is one cycle after accept plus any wait states. HRDATA is 0 in every other state.
- Back-to-back: a read whose address phase coincides with a write's data phase to the same word returns the newly written data. This holds because the write commits at the edge that starts the read's data phase.
- Errored transfers never modify memory; HRDATA is 0 during ERR1 and ERR2.
- Master abort: if the master drives HTRANS=IDLE in ERR2, the block returns to IDLE.
- Reset: HRESET high at an edge forces state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0 and clears the wait counter and data-phase registers.
  - A pending write data phase is dropped.
  - Memory contents are not cleared.
- Word index: (HADDR - BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits.

Optional Feature:
Macro AHB_SRAM_WAIT_EN.
- Defined: every OKAY data phase inserts WAIT_CYCLES cycles with HREADYOUT=0 before the DATA cycle. This models a slow memory and exercises the DMA's HREADY handling.
- Undefined: the WAIT state and the counter are not synthesised; every OKAY transfer is zero-wait and WAIT_CYCLES is ignored.
- Error responses are identical in both builds.

Test Plan:
1. Word write, then read back: write 0xDEADBEEF to BASE+0x10, then read BASE+0x10 -> HRDATA=0xDEADBEEF in the read data phase, HRESP=0, HREADYOUT=1 every cycle (macro undefined).
2. Byte and halfword writes: word 0x00000000 at BASE+0x20; write byte 0xAA to BASE+0x21, then halfword 0x1234 to BASE+0x22 -> read word = 0x1234AA00.
3. Errors: word read at BASE+0x02, then any access at BASE+DEPTH_WORDS*4 -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, and memory is unchanged.
4. Pipelined traffic: NONSEQ write to BASE+0x40 followed immediately by a SEQ read of BASE+0x40 -> read returns the written value with no stall.
5. Wait states: with AHB_SRAM_WAIT_EN and WAIT_CYCLES=2, a read -> exactly 2 cycles of HREADYOUT=0, then data with HREADYOUT=1; HTRANS and HADDR held by the master are not re-accepted during the waits.
6. Reset mid-write: assert HRESET during a write data phase -> next cycle HREADYOUT=1/HRESP=0, the target word keeps its old value, and other words are retained.
